// File: rtl/drrip_port_arbiter_if.sv
// Requester and replacement-engine signal bundle for drrip_port_arbiter.
// master = requesters plus engine, slave = arbiter.
interface drrip_port_arbiter_if #(
  parameter int NUM_REQ         = 4,
  parameter int SET_INDEX_WIDTH = 3
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_is_miss;
  logic [NUM_REQ*SET_INDEX_WIDTH-1:0] req_set;
  logic [NUM_REQ*4-1:0]               req_way;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [3:0]                         rsp_victim_way;
  logic                               rsp_timeout;
  logic                               eng_valid;
  logic                               eng_hit;
  logic                               eng_miss;
  logic [SET_INDEX_WIDTH-1:0]         eng_set_index;
  logic [3:0]                         eng_access_way;
  logic [3:0]                         eng_victim_way;
  logic                               eng_victim_ready;

  modport master (
    output req_valid, req_is_miss, req_set, req_way,
    input  req_ready, rsp_valid, rsp_victim_way, rsp_timeout,
    input  eng_valid, eng_hit, eng_miss, eng_set_index, eng_access_way,
    output eng_victim_way, eng_victim_ready
  );

  modport slave (
    input  req_valid, req_is_miss, req_set, req_way,
    output req_ready, rsp_valid, rsp_victim_way, rsp_timeout,
    output eng_valid, eng_hit, eng_miss, eng_set_index, eng_access_way,
    input  eng_victim_way, eng_victim_ready
  );
endinterface

// File: rtl/drrip_port_arbiter.sv
// Round-robin arbiter serialising requester hit/miss accesses onto a single
// DRRIP replacement engine, with miss victim wait, timeout and response.
module drrip_port_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int NUM_SETS        = 8,
  parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
  parameter int MISS_TIMEOUT    = 16,
  localparam int GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  drrip_port_arbiter_if.slave   bus,
  output logic                  busy,
  output logic [GW-1:0]         grant_id,
  output logic [7:0]            timeout_count
);
  typedef enum logic [2:0] {IDLE, HIT_ISSUE, MISS_WAIT, MISS_HOLD, RESP} state_t;

  localparam int CW  = $clog2(MISS_TIMEOUT + 1);
  localparam int SIW = SET_INDEX_WIDTH;

  state_t         state, state_nx;
  logic [GW-1:0]  last_grant, gnt, cand;
  logic           gnt_found;
  logic [SIW-1:0] lat_set;
  logic [3:0]     lat_way, lat_victim;
  logic           lat_timeout;
  logic [CW-1:0]  wait_cnt;
  logic           wait_last;
  logic [SIW-1:0] set_arr [NUM_REQ];
  logic [3:0]     way_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign set_arr[i] = bus.req_set[i*SIW +: SIW];
    assign way_arr[i] = bus.req_way[i*4 +: 4];
  end

  assign busy      = (state != IDLE);
  assign wait_last = (wait_cnt == CW'(MISS_TIMEOUT - 1));

  // Round-robin search starting one past the previous winner.
  always_comb begin
    gnt       = last_grant;
    gnt_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((32'(last_grant) + k) % 32'(NUM_REQ));
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt       = cand;
        gnt_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx           = state;
    bus.req_ready      = '0;
    bus.rsp_valid      = '0;
    bus.rsp_victim_way = '0;
    bus.rsp_timeout    = 1'b0;
    bus.eng_valid      = 1'b0;
    bus.eng_hit        = 1'b0;
    bus.eng_miss       = 1'b0;
    bus.eng_set_index  = '0;
    bus.eng_access_way = '0;
    unique case (state)
      IDLE: begin
        if (gnt_found) begin
          // Gated so req_ready is also held low while reset is asserted.
          bus.req_ready[gnt] = rst_n;
          state_nx = bus.req_is_miss[gnt] ? MISS_WAIT : HIT_ISSUE;
        end
      end
      HIT_ISSUE: begin
        bus.eng_valid      = 1'b1;
        bus.eng_hit        = 1'b1;
        bus.eng_set_index  = lat_set;
        bus.eng_access_way = lat_way;
        state_nx           = RESP;
      end
      MISS_WAIT: begin
        bus.eng_valid      = 1'b1;
        bus.eng_miss       = 1'b1;
        bus.eng_set_index  = lat_set;
        bus.eng_access_way = lat_way;
        if (bus.eng_victim_ready) state_nx = MISS_HOLD;
        else if (wait_last)       state_nx = RESP;
      end
      MISS_HOLD: begin
        bus.eng_valid      = 1'b1;
        bus.eng_miss       = 1'b1;
        bus.eng_set_index  = lat_set;
        bus.eng_access_way = lat_way;
        state_nx           = RESP;
      end
      RESP: begin
        bus.rsp_valid[grant_id] = 1'b1;
        bus.rsp_victim_way      = lat_victim;
        bus.rsp_timeout         = lat_timeout;
        state_nx                = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= GW'(NUM_REQ - 1);
      grant_id      <= '0;
      lat_set       <= '0;
      lat_way       <= '0;
      lat_victim    <= '0;
      lat_timeout   <= 1'b0;
      wait_cnt      <= '0;
      timeout_count <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            last_grant  <= gnt;
            grant_id    <= gnt;
            lat_set     <= set_arr[gnt];
            lat_way     <= way_arr[gnt];
            lat_victim  <= '0;
            lat_timeout <= 1'b0;
            wait_cnt    <= '0;
          end
        end
        MISS_WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
          // Victim ready takes priority over a coincident timeout.
          if (bus.eng_victim_ready) begin
            lat_victim <= bus.eng_victim_way;
          end else if (wait_last) begin
            lat_timeout <= 1'b1;
            lat_victim  <= '0;
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_drrip_port_arbiter.sv
// Randomised and directed bench for drrip_port_arbiter against a
// transaction-timing reference model.
module tb_drrip_port_arbiter;
  localparam int NR = 4;
  localparam int SW = 3;
  localparam int MT = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] grant_id;
  logic [7:0] timeout_count;

  drrip_port_arbiter_if #(.NUM_REQ(NR), .SET_INDEX_WIDTH(SW)) bus ();

  drrip_port_arbiter #(
    .NUM_REQ(NR), .NUM_SETS(8), .SET_INDEX_WIDTH(SW), .MISS_TIMEOUT(MT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy(busy), .grant_id(grant_id), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  // stimulus state
  bit          rst_v;
  bit          pv [NR];
  bit          pm [NR];
  logic [SW-1:0] ps [NR];
  logic [3:0]  pw [NR];
  bit          evr;
  logic [3:0]  evw;

  // reference model: one in-flight transaction described by its timestamps
  int          cyc;
  bit          act;
  int          t_id, t_g, t_res;
  bit          t_miss, t_to;
  logic [SW-1:0] t_set;
  logic [3:0]  t_way, t_vict;
  int          last_g, gid, tc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, a, e);
    end
  endtask

  task automatic cycle();
    logic [NR-1:0] e_rdy, e_rsp;
    logic [3:0]    e_vw, e_aw;
    logic [SW-1:0] e_set;
    logic          e_to, e_ev, e_eh, e_em, e_busy;
    int            e_gid, e_tc, d, g;
    @(negedge clk);
    cyc++;
    rst_n = rst_v;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]        = pv[i];
      bus.req_is_miss[i]      = pm[i];
      bus.req_set[i*SW +: SW] = ps[i];
      bus.req_way[i*4 +: 4]   = pw[i];
    end
    bus.eng_victim_ready = evr;
    bus.eng_victim_way   = evw;
    #1;
    e_rdy = '0; e_rsp = '0; e_vw = '0; e_aw = '0; e_set = '0;
    e_to = 0; e_ev = 0; e_eh = 0; e_em = 0; e_busy = 0;
    if (!rst_v) begin
      act = 0; last_g = NR - 1; gid = 0; tc = 0;
    end
    e_gid = gid;
    e_tc  = tc;
    if (rst_v) begin
      if (!act) begin
        g = -1;
        for (int k = 1; k <= NR; k++)
          if (g < 0 && pv[(last_g + k) % NR]) g = (last_g + k) % NR;
        if (g >= 0) begin
          e_rdy[g] = 1'b1;
          act = 1; t_id = g; t_miss = pm[g]; t_set = ps[g]; t_way = pw[g];
          t_g = cyc; t_res = -1; t_to = 0; t_vict = '0;
          last_g = g; gid = g; pv[g] = 0;
        end
      end else begin
        e_busy = 1;
        d = cyc - t_g;
        if (!t_miss) begin
          if (d == 1) begin
            e_ev = 1; e_eh = 1; e_set = t_set; e_aw = t_way;
          end else begin
            e_rsp[t_id] = 1'b1; act = 0;
          end
        end else if (t_res < 0 || (!t_to && cyc == t_res + 1)) begin
          e_ev = 1; e_em = 1; e_set = t_set; e_aw = t_way;
          if (t_res < 0) begin
            if (evr) begin
              t_res = cyc; t_vict = evw;
            end else if (d == MT) begin
              t_res = cyc; t_to = 1;
              if (tc < 255) tc++;
            end
          end
        end else begin
          e_rsp[t_id] = 1'b1; e_vw = t_vict; e_to = t_to; act = 0;
        end
      end
    end
    chk("req_ready",      bus.req_ready,      e_rdy);
    chk("rsp_valid",      bus.rsp_valid,      e_rsp);
    chk("rsp_victim_way", bus.rsp_victim_way, e_vw);
    chk("rsp_timeout",    bus.rsp_timeout,    e_to);
    chk("eng_valid",      bus.eng_valid,      e_ev);
    chk("eng_hit",        bus.eng_hit,        e_eh);
    chk("eng_miss",       bus.eng_miss,       e_em);
    chk("eng_set_index",  bus.eng_set_index,  e_set);
    chk("eng_access_way", bus.eng_access_way, e_aw);
    chk("busy",           busy,               e_busy);
    chk("grant_id",       grant_id,           e_gid);
    chk("timeout_count",  timeout_count,      e_tc);
  endtask

  task automatic do_reset();
    rst_v = 0;
    cycle();
    cycle();
    rst_v = 1;
  endtask

  // Drive one pending miss to completion; the engine raises victim_ready on
  // the rdy_at-th engine-miss cycle (0 = never).
  task automatic run_miss(input int rdy_at, input logic [3:0] way, output int nm,
                          output logic [3:0] rv, output logic [3:0] vw,
                          output logic to, output int ok);
    nm = 0; ok = 0; rv = '0; vw = '0; to = 0;
    for (int c = 0; c < 40 && ok == 0; c++) begin
      evr = (rdy_at > 0 && nm == rdy_at - 1);
      evw = evr ? way : 4'hA;
      cycle();
      if (bus.eng_miss) nm++;
      if (bus.rsp_valid != '0) begin
        ok = 1; rv = bus.rsp_valid; vw = bus.rsp_victim_way; to = bus.rsp_timeout;
      end
    end
    evr = 0;
  endtask

  task automatic gen_reqs(input bit force_miss);
    for (int i = 0; i < NR; i++)
      if (!pv[i] && $urandom_range(0, 2) == 0) begin
        pv[i] = 1;
        pm[i] = force_miss ? 1'b1 : 1'($urandom_range(0, 1));
        ps[i] = SW'($urandom);
        pw[i] = 4'($urandom);
      end
  endtask

  initial begin
    int nm, ok, mode;
    logic [3:0] rv, vw;
    logic to;
    int gidx[$];
    int gcyc[$];
    rst_n = 1'b0;
    rst_v = 0; evr = 0; evw = '0; cyc = 0; act = 0;
    last_g = NR - 1; gid = 0; tc = 0;
    for (int i = 0; i < NR; i++) begin pv[i] = 0; pm[i] = 0; ps[i] = '0; pw[i] = '0; end

    // reset state and single hit
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_tcount", timeout_count, 0);
    cycle();
    pv[2] = 1; pm[2] = 0; ps[2] = 3'd5; pw[2] = 4'd1;
    cycle();
    chk("hit_ready", bus.req_ready, 4'b0100);
    cycle();
    chk("hit_eng", {bus.eng_valid, bus.eng_hit, bus.eng_miss}, 3'b110);
    chk("hit_set_way", {bus.eng_set_index, bus.eng_access_way}, {3'd5, 4'd1});
    cycle();
    chk("hit_rsp", bus.rsp_valid, 4'b0100);
    chk("hit_victim", bus.rsp_victim_way, 0);

    // single miss with victim on the third wait cycle
    pv[0] = 1; pm[0] = 1; ps[0] = '0; pw[0] = '0;
    run_miss(3, 4'd3, nm, rv, vw, to, ok);
    chk("miss_done", ok, 1);
    chk("miss_eng_cycles", nm, 4);
    chk("miss_rsp", rv, 4'b0001);
    chk("miss_victim", vw, 3);
    chk("miss_timeout", to, 0);

    // fairness
    do_reset();
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < NR; i++) begin pv[i] = 1; pm[i] = 0; end
      cycle();
      for (int i = 0; i < NR; i++)
        if (bus.req_ready[i]) begin gidx.push_back(i); gcyc.push_back(cyc); end
    end
    for (int i = 0; i < NR; i++) pv[i] = 0;
    cycle(); cycle(); cycle();
    chk("fair_grants", gidx.size() >= 5, 1);
    if (gidx.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("fair_order", gidx[i], i % 4);
      for (int i = 1; i < 5; i++) chk("fair_gap", gcyc[i] - gcyc[i-1], 3);
    end

    // timeout
    do_reset();
    pv[0] = 1; pm[0] = 1; ps[0] = 3'd2; pw[0] = 4'd7;
    run_miss(0, 4'd0, nm, rv, vw, to, ok);
    chk("to_done", ok, 1);
    chk("to_eng_cycles", nm, 16);
    chk("to_flag", to, 1);
    chk("to_victim", vw, 0);
    chk("to_count", timeout_count, 1);

    // victim ready on the final timeout cycle wins
    pv[0] = 1; pm[0] = 1; ps[0] = 3'd6; pw[0] = 4'd2;
    run_miss(16, 4'd5, nm, rv, vw, to, ok);
    chk("tie_done", ok, 1);
    chk("tie_eng_cycles", nm, 17);
    chk("tie_flag", to, 0);
    chk("tie_victim", vw, 5);
    chk("tie_count", timeout_count, 1);

    // reset in the middle of a miss
    pv[1] = 1; pm[1] = 1; ps[1] = 3'd4; pw[1] = 4'd9;
    evr = 0;
    cycle(); cycle(); cycle();
    chk("mid_miss_active", bus.eng_miss, 1);
    rst_v = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_drop", {busy, bus.eng_valid, bus.eng_miss}, 3'b000);
    cycle(); cycle();
    rst_v = 1;
    for (int i = 0; i < NR; i++) begin pv[i] = (i != 2); pm[i] = 0; end
    cycle();
    chk("mid_rst_next_grant", bus.req_ready, 4'b0001);

    // randomised traffic with varying engine responsiveness
    for (int n = 0; n < 4000; n++) begin
      mode = (n / 500) % 3;
      gen_reqs(0);
      case (mode)
        0:       evr = ($urandom_range(0, 3) == 0);
        1:       evr = ($urandom_range(0, 39) == 0);
        default: evr = 0;
      endcase
      evw = 4'($urandom);
      cycle();
    end

    // sustained timeouts drive the counter into saturation
    evr = 0;
    for (int n = 0; n < 6000; n++) begin
      gen_reqs(1);
      evw = 4'($urandom);
      cycle();
    end
    chk("tcount_saturated", timeout_count, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/drrip_port_arbiter.md
DRRIP_PORT_ARBITER -- requirements
Module: drrip_port_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- NUM_REQ, default 4: number of requester ports.
- NUM_SETS, default 8: number of cache sets.
- SET_INDEX_WIDTH, default $clog2(NUM_SETS): set index width.
- MISS_TIMEOUT, default 16: maximum MISS_WAIT cycles.

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request.
- req_is_miss  in  NUM_REQ  1 = miss access, 0 = hit access.
- req_set  in  NUM_REQ*SET_INDEX_WIDTH  packed set index, requester i at slice i.
- req_way  in  NUM_REQ*4  packed access way, requester i at slice i.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_victim_way  out  4  victim way for completed miss.
- rsp_timeout  out  1  completed miss timed out.
- eng_valid, eng_hit, eng_miss  out  1 each  replacement-engine access controls.
- eng_set_index  out  SET_INDEX_WIDTH  engine set index.
- eng_access_way  out  4  engine access way.
- eng_victim_way  in  4  engine victim way.
- eng_victim_ready  in  1  engine victim valid.
- busy  out  1  FSM not in IDLE.
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester.
- timeout_count  out  8  saturating timeout counter.

Function
REQ-003 The FSM SHALL have the states IDLE, HIT_ISSUE, MISS_WAIT, MISS_HOLD and RESP; busy = (state != IDLE).
REQ-004 In IDLE with any req_valid set, the block SHALL grant round-robin, searching upward from (last_grant+1) mod NUM_REQ.
REQ-005 On a grant, the block SHALL assert req_ready[g] combinationally for that cycle only, latch set, way and is_miss, and update last_grant and grant_id to g.
REQ-006 On a grant, the next state SHALL be MISS_WAIT if the latched is_miss = 1, otherwise HIT_ISSUE.
REQ-007 req_ready SHALL be all-zero in every state other than IDLE; requesters hold req_valid until accepted.
REQ-008 In HIT_ISSUE, the block SHALL drive eng_valid=1 and eng_hit=1 for exactly one cycle, then go to RESP.
REQ-009 In MISS_WAIT, the block SHALL drive eng_valid=1 and eng_miss=1 continuously and increment a wait counter that is cleared on entry.
REQ-010 In MISS_WAIT, when eng_victim_ready is sampled 1, the block SHALL latch eng_victim_way and go to MISS_HOLD.
REQ-011 In MISS_WAIT, when the counter reaches MISS_TIMEOUT-1 with eng_victim_ready=0, the block SHALL set the timeout flag, latch victim way 0, and go to RESP.
REQ-012 If eng_victim_ready and the timeout coincide, the ready SHALL win and no timeout SHALL be recorded.
REQ-013 In MISS_HOLD, the block SHALL keep eng_valid=1 and eng_miss=1 for one more cycle (engine insertion cycle), then go to RESP.
REQ-014 In RESP, the block SHALL drive rsp_valid[g]=1 for one cycle with rsp_victim_way and rsp_timeout from the latches (0 and 0 for hits), then return to IDLE.
REQ-015 eng_set_index and eng_access_way SHALL carry the latched values in HIT_ISSUE, MISS_WAIT and MISS_HOLD, and 0 elsewhere; eng_valid, eng_hit and eng_miss SHALL be 0 outside those states.
REQ-016 Latency: grant at T gives a hit response at T+2; a miss whose victim_ready is sampled at W gives a response at W+2.
REQ-017 eng_victim_ready SHALL be ignored outside MISS_WAIT.
REQ-018 timeout_count SHALL increment on each timeout and saturate at 255.
REQ-019 rsp_victim_way and rsp_timeout SHALL be 0 whenever rsp_valid is all-zero.

Reset
REQ-020 rst_n low SHALL asynchronously force:
- state to IDLE;
- all outputs to 0;
- all latches, the wait counter and timeout_count to 0;
- last_grant to NUM_REQ-1, so the first grant after reset goes to requester 0.

REQ-021 A reset asserted mid-operation SHALL abandon the in-flight access with no rsp_valid pulse.

Verification
REQ-022 Single hit: reset, then req_valid=0100, set 5, way 1, hit -> req_ready=0100 at T; eng_valid=eng_hit=1, set 5, way 1 at T+1; rsp_valid=0100, victim 0 at T+2.
REQ-023 Single miss: req0 miss, set 0, way 0; engine raises victim_ready with way 3 on the 3rd MISS_WAIT cycle -> eng_miss high 4 cycles; rsp_valid=0001, rsp_victim_way=3, rsp_timeout=0.
REQ-024 Fairness: all four requesters assert hits continuously from reset -> grant order 0,1,2,3,0, one grant every 3 cycles.
REQ-025 Timeout: miss with eng_victim_ready held 0, MISS_TIMEOUT=16 -> exactly 16 MISS_WAIT cycles; rsp_timeout=1, rsp_victim_way=0, timeout_count=1.
REQ-026 Reset mid-miss: rst_n low during MISS_WAIT -> eng_valid, eng_miss and busy drop to 0 immediately; no rsp_valid; next grant goes to req0.
REQ-027 Tie: victim_ready on the final timeout cycle -> rsp_timeout=0, victim way returned, timeout_count unchanged.
